// File: rtl/fe_switch_sequencer_if.sv
// Serial setting bus used to program the front-end switch sequencer.
// Signals:
//   serial_addr    7-bit register address
//   serial_data    32-bit write data
//   serial_strobe  one-cycle write strobe
// Modports: master drives the bus (serial_io / testbench), slave receives it (sequencer).
interface fe_switch_sequencer_if;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;

    modport master (
        output serial_addr,
        output serial_data,
        output serial_strobe
    );

    modport slave (
        input serial_addr,
        input serial_data,
        input serial_strobe
    );
endinterface

// File: rtl/fe_switch_sequencer.sv
// WSA1000 RF front-end retuning sequencer (adcclk domain).
// Blanks RX, applies RF switch / filter-bank / VCO latch-enable changes, then waits for the
// front end to settle before handing enable_rx back to rx_chain.
// Ports:
//   clock          adcclk
//   reset          synchronous, active-high
//   bus            serial setting bus (slave modport): CTRL and SETTLE register writes
//   enable_rx_in   enable_rx from master_control
//   vco_muxout     VCO lock detect (only used when FE_LOCK_WAIT_EN is defined)
//   enable_rx_out  enable_rx gated off while a sequence runs
//   vsw            {VSWD,VSWC,VSWB,VSWA}
//   filter_sel     {FILTER_A1,FILTER_A0}
//   vco_le         single-cycle VCO latch-enable pulse
//   busy           sequence in progress
//   status         readback word
// Optional feature macro: FE_LOCK_WAIT_EN -- after settling, wait for VCO lock (with timeout).
module fe_switch_sequencer #(
    parameter logic [6:0]  CTRL_ADDR      = 7'd64,
    parameter logic [6:0]  SETTLE_ADDR    = 7'd65,
    parameter int unsigned BLANK_CYCLES   = 2,
    parameter logic [15:0] SETTLE_DEFAULT = 16'd500
) (
    input  logic                         clock,
    input  logic                         reset,
    fe_switch_sequencer_if.slave         bus,
    input  logic                         enable_rx_in,
    input  logic                         vco_muxout,
    output logic                         enable_rx_out,
    output logic [3:0]                   vsw,
    output logic [1:0]                   filter_sel,
    output logic                         vco_le,
    output logic                         busy,
    output logic [31:0]                  status
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StBlank  = 3'd1,
        StApply  = 3'd2,
        StSettle = 3'd3,
        StLock   = 3'd4
    } state_e;

    typedef struct packed {
        logic       vco_req;
        logic [1:0] filter;
        logic [3:0] vsw;
    } req_t;

    localparam logic [15:0] BlankLoad = 16'(BLANK_CYCLES);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] settle_q, settle_d;
    req_t        shadow_q, shadow_d;  // latest CTRL write
    req_t        run_q, run_d;        // request owned by the running sequence
    logic        pending_q, pending_d;
    logic        coal_q, coal_d;
    logic        lock_to_q, lock_to_d;
    logic [3:0]  vsw_q, vsw_d;
    logic [1:0]  filter_q, filter_d;

    logic ctrl_wr, settle_wr, busy_int;
    logic seq_done, start, lock_to_evt;

    assign ctrl_wr   = bus.serial_strobe && (bus.serial_addr == CTRL_ADDR);
    assign settle_wr = bus.serial_strobe && (bus.serial_addr == SETTLE_ADDR);
    assign busy_int  = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        settle_d    = settle_q;
        shadow_d    = shadow_q;
        run_d       = run_q;
        pending_d   = pending_q;
        coal_d      = coal_q;
        lock_to_d   = lock_to_q;
        vsw_d       = vsw_q;
        filter_d    = filter_q;
        seq_done    = 1'b0;
        start       = 1'b0;
        lock_to_evt = 1'b0;

        if (settle_wr) begin
            settle_d = bus.serial_data[15:0];
        end

        if (ctrl_wr) begin
            shadow_d = '{vco_req: bus.serial_data[8],
                         filter:  bus.serial_data[5:4],
                         vsw:     bus.serial_data[3:0]};
            if (busy_int) begin
                pending_d = 1'b1;
            end
            if (bus.serial_data[9]) begin
                coal_d    = 1'b0;
                lock_to_d = 1'b0;
            end
            // A clear that lands mid-sequence is itself a coalesced write.
            if (busy_int) begin
                coal_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (ctrl_wr) begin
                    start = 1'b1;
                end
            end
            StBlank: begin
                if (cnt_q <= 16'd1) begin
                    state_d = StApply;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StApply: begin
                vsw_d    = run_q.vsw;
                filter_d = run_q.filter;
                if (settle_q == 16'd0) begin
`ifdef FE_LOCK_WAIT_EN
                    state_d = StLock;
                    cnt_d   = settle_q;
`else
                    seq_done = 1'b1;
`endif
                end else begin
                    state_d = StSettle;
                    cnt_d   = settle_q;
                end
            end
            StSettle: begin
                if (cnt_q <= 16'd1) begin
`ifdef FE_LOCK_WAIT_EN
                    state_d = StLock;
                    cnt_d   = settle_q;
`else
                    seq_done = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef FE_LOCK_WAIT_EN
            StLock: begin
                // A count of 0 or 1 both mean this is the last allowed LOCK cycle.
                if (vco_muxout) begin
                    seq_done = 1'b1;
                end else if (cnt_q <= 16'd1) begin
                    seq_done    = 1'b1;
                    lock_to_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        // A write in the exit cycle counts as pending: chain straight into BLANK.
        if (seq_done) begin
            if (pending_q || ctrl_wr) begin
                start = 1'b1;
            end else begin
                state_d = StIdle;
            end
        end

        if (start) begin
            state_d   = StBlank;
            cnt_d     = BlankLoad;
            pending_d = 1'b0;
            run_d     = shadow_d;
        end

        if (lock_to_evt) begin
            lock_to_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            settle_q  <= SETTLE_DEFAULT;
            shadow_q  <= '0;
            run_q     <= '0;
            pending_q <= 1'b0;
            coal_q    <= 1'b0;
            lock_to_q <= 1'b0;
            vsw_q     <= '0;
            filter_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            settle_q  <= settle_d;
            shadow_q  <= shadow_d;
            run_q     <= run_d;
            pending_q <= pending_d;
            coal_q    <= coal_d;
            lock_to_q <= lock_to_d;
            vsw_q     <= vsw_d;
            filter_q  <= filter_d;
        end
    end

    logic lock_bit, mux_bit;
`ifdef FE_LOCK_WAIT_EN
    assign lock_bit = lock_to_q;
    assign mux_bit  = vco_muxout;
`else
    assign lock_bit = 1'b0;
    assign mux_bit  = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{bus.serial_data[31:16], vco_muxout, lock_to_q};

    assign enable_rx_out = enable_rx_in && !busy_int;
    assign busy          = busy_int;
    assign vsw           = vsw_q;
    assign filter_sel    = filter_q;
    assign vco_le        = (state_q == StApply) && run_q.vco_req;
    assign status        = {lock_bit, coal_q, 3'b000, state_q, 6'b000000,
                            mux_bit, pending_q, 2'b00, filter_q, vsw_q, 8'h00};

endmodule
